// File: rtl/pc_seq_pkg.sv
// Shared state encoding, opcode constants and decode helper for the program-counter sequencer.
package pc_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPH,
    S_OPL,
    S_JUMP,
    S_EXEC,
    S_EXEC_WAIT,
    S_HALT
  } seq_state_e;

  localparam logic [DATA_W-1:0] OP_JUMP = 8'hF0;
  localparam logic [DATA_W-1:0] OP_JMPZ = 8'hF1;
  localparam logic [DATA_W-1:0] OP_HALT = 8'hFF;

  // Both branch forms carry a two-byte target operand.
  function automatic logic is_branch(input logic [DATA_W-1:0] op);
    return (op == OP_JUMP) || (op == OP_JMPZ);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction fetch/decode sequencer: pulls opcode and jump operands from program memory
// and issues PC increment/load strobes and execute handshakes.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              finish_signal,
  input  logic              z_flag,
  input  logic              exec_done,
  output logic              mem_read,
  output logic              fetch,
  output logic              pc_inc,
  output logic              pc_load_jump,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] tr,
  output logic [DATA_W-1:0] mbr,
  output logic              exec_go,
  output logic              busy,
  output logic              halted
);

  seq_state_e state;
  logic       rd_phase;
  logic       take_branch;

  // A memory read is outstanding in FETCH (unless the program has ended) and both operand states.
  always_comb begin
    rd_phase = 1'b0;
    unique case (state)
      S_FETCH:      rd_phase = !finish_signal;
      S_OPH, S_OPL: rd_phase = 1'b1;
      default:      rd_phase = 1'b0;
    endcase
  end

  assign mem_read     = rd_phase;
  assign fetch        = rd_phase;
  assign pc_inc       = rd_phase && mem_ready;
  assign pc_load_jump = (state == S_JUMP);
  assign exec_go      = (state == S_EXEC);
  assign busy         = (state != S_IDLE) && (state != S_HALT);
  assign halted       = (state == S_HALT);

  assign take_branch  = (ir == OP_JUMP) || ((ir == OP_JMPZ) && z_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      tr    <= '0;
      mbr   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (finish_signal) begin
            state <= S_HALT;
          end else if (mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (ir == OP_HALT)     state <= S_HALT;
          else if (is_branch(ir)) state <= S_OPH;
          else                   state <= S_EXEC;
        end
        S_OPH: begin
          if (mem_ready) begin
            tr    <= mem_rdata;
            state <= S_OPL;
          end
        end
        S_OPL: begin
          // Not-taken JMPZ falls straight through: PC already points past the operands.
          if (mem_ready) begin
            mbr   <= mem_rdata;
            state <= take_branch ? S_JUMP : S_FETCH;
          end
        end
        S_JUMP:      state <= S_FETCH;
        S_EXEC:      state <= S_EXEC_WAIT;
        S_EXEC_WAIT: begin
          if (exec_done) state <= S_FETCH;
        end
        S_HALT:      state <= S_HALT;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a byte-memory/PC model and an auto exec_done responder.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       finish_signal = 1'b0;
  logic       z_flag = 1'b0;
  logic       exec_done;
  logic       mem_read, fetch, pc_inc, pc_load_jump, exec_go, busy, halted;
  logic [7:0] ir, tr, mbr;

  logic [7:0]  prog [0:65535];
  logic [15:0] pc;
  int n_inc, n_jmp, n_go, wait_cnt, done_cnt;
  int n_both = 0;
  int n_rf = 0;
  int mem_delay = 1;
  logic force_rdy = 1'b0;
  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .finish_signal(finish_signal), .z_flag(z_flag), .exec_done(exec_done),
    .mem_read(mem_read), .fetch(fetch), .pc_inc(pc_inc), .pc_load_jump(pc_load_jump),
    .ir(ir), .tr(tr), .mbr(mbr), .exec_go(exec_go), .busy(busy), .halted(halted)
  );

  assign mem_rdata = prog[pc];
  assign mem_ready = force_rdy | (mem_read && (wait_cnt == mem_delay));
  assign exec_done = (done_cnt == 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0; n_inc <= 0; n_jmp <= 0; n_go <= 0; wait_cnt <= 0; done_cnt <= 0;
    end else begin
      if (pc_inc) begin
        pc    <= pc + 16'd1;
        n_inc <= n_inc + 1;
      end else if (pc_load_jump) begin
        pc <= {tr, mbr};
      end
      if (pc_load_jump) n_jmp <= n_jmp + 1;
      if (exec_go) n_go <= n_go + 1;
      wait_cnt <= (!mem_read || mem_ready) ? 0 : wait_cnt + 1;
      if (exec_go)             done_cnt <= 1;
      else if (done_cnt == 2)  done_cnt <= 0;
      else if (done_cnt != 0)  done_cnt <= done_cnt + 1;
    end
    if (pc_inc && pc_load_jump) n_both <= n_both + 1;
    if (mem_read != fetch)      n_rf <= n_rf + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; finish_signal = 1'b0; z_flag = 1'b0; force_rdy = 1'b0;
    mem_delay = 1;
    for (int i = 0; i < 8; i++) prog[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    prog[0] = b0; prog[1] = b1; prog[2] = b2;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    #1;
    check_val("rst_mem_read", mem_read, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_ir", ir, 8'h00);
    check_val("rst_trmbr", {tr, mbr}, 16'h0000);
    do_reset();
    check_val("idle_no_read", mem_read, 0);

    // Plain instruction: fetch, decode, execute, wait for done
    load3(8'h12, 8'h00, 8'h00);
    pulse_start();
    for (int i = 0; i < 100 && !exec_done; i++) @(negedge clk);
    check_val("exec_done_seen", exec_done, 1);
    @(negedge clk);
    check_val("ex_back_fetch", mem_read, 1);
    check_val("ex_fetch_eq", fetch, 1);
    check_val("ex_inc_cnt", n_inc, 1);
    check_val("ex_ir", ir, 8'h12);
    check_val("ex_go_cnt", n_go, 1);

    // Unconditional jump
    do_reset();
    load3(8'hF0, 8'h01, 8'h4D);
    pulse_start();
    for (int i = 0; i < 100 && !pc_load_jump; i++) @(negedge clk);
    check_val("jmp_strobe", pc_load_jump, 1);
    check_val("jmp_target", {tr, mbr}, 16'h014D);
    check_val("jmp_inc_cnt", n_inc, 3);
    check_val("jmp_no_inc", pc_inc, 0);
    @(negedge clk);
    check_val("jmp_one_cycle", pc_load_jump, 0);
    check_val("jmp_then_fetch", mem_read, 1);
    check_val("jmp_pc", pc, 16'h014D);
    check_val("jmp_cnt", n_jmp, 1);

    // JMPZ not taken
    do_reset();
    load3(8'hF1, 8'h00, 8'h20);
    pulse_start();
    for (int i = 0; i < 100 && n_inc != 3; i++) @(negedge clk);
    check_val("jz0_inc_cnt", n_inc, 3);
    check_val("jz0_fetch", mem_read, 1);
    check_val("jz0_no_jump", n_jmp, 0);
    check_val("jz0_pc", pc, 16'h0003);

    // JMPZ taken
    do_reset();
    load3(8'hF1, 8'h00, 8'h20);
    z_flag = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && !pc_load_jump; i++) @(negedge clk);
    check_val("jz1_strobe", pc_load_jump, 1);
    check_val("jz1_target", {tr, mbr}, 16'h0020);
    @(negedge clk);
    check_val("jz1_pc", pc, 16'h0020);

    // Stray mem_ready ignored, then slow memory in FETCH
    do_reset();
    prog[0] = 8'h77;
    force_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    force_rdy = 1'b0;
    check_val("stray_rdy_ir", ir, 8'h00);
    check_val("stray_rdy_inc", n_inc, 0);
    mem_delay = 5;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_read) cnt++;
      if (pc_inc) break;
      @(negedge clk);
    end
    check_val("slow_read_cycles", cnt, 6);
    @(negedge clk);
    check_val("slow_inc_cnt", n_inc, 1);
    check_val("slow_ir", ir, 8'h77);

    // finish_signal on FETCH entry
    do_reset();
    finish_signal = 1'b1;
    pulse_start();
    check_val("fin_no_read", mem_read, 0);
    check_val("fin_no_inc", pc_inc, 0);
    @(negedge clk);
    check_val("fin_halted", halted, 1);
    check_val("fin_not_busy", busy, 0);
    pulse_start();
    @(negedge clk);
    check_val("fin_start_ignored", halted, 1);
    check_val("fin_no_read2", mem_read, 0);

    // HALT opcode
    do_reset();
    prog[0] = 8'hFF;
    pulse_start();
    for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
    check_val("hop_halted", halted, 1);
    check_val("hop_ir", ir, 8'hFF);
    check_val("hop_inc_cnt", n_inc, 1);
    check_val("hop_no_go", n_go, 0);

    // Reset during the low-operand wait
    do_reset();
    load3(8'hF0, 8'h01, 8'h4D);
    mem_delay = 4;
    pulse_start();
    for (int i = 0; i < 100 && n_inc != 2; i++) @(negedge clk);
    check_val("opl_reached", n_inc, 2);
    check_val("opl_reading", mem_read, 1);
    check_val("opl_tr", tr, 8'h01);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_read", mem_read, 0);
    check_val("mid_rst_inc", pc_inc, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_regs", {ir, tr, mbr}, 24'h000000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_val("post_rst_idle", busy, 0);
    pulse_start();
    check_val("post_rst_fetch", mem_read, 1);

    check_val("inc_jump_exclusive", n_both, 0);
    check_val("read_fetch_equal", n_rf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1);
  end

endmodule
